// File: rtl/timer_reload_ctrl.sv
// rtl/timer_reload_ctrl.sv - CPU/timer bus bridge with mtimecmp auto-reload engine
// and a pending/enable interrupt register.
module timer_reload_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_write_data,
    input  logic        cpu_write_enable,
    output logic [31:0] cpu_read_data,
    output logic        cpu_stall,
    output logic [31:0] tmr_address,
    output logic [31:0] tmr_write_data,
    output logic        tmr_write_enable,
    input  logic [31:0] tmr_read_data,
    input  logic        tmr_interrupt,
    output logic        irq
);
    localparam logic [31:0] TMR_BASE    = 32'hFFFF_0000;
    localparam logic [31:0] TMR_LAST    = 32'hFFFF_000C;
    localparam logic [31:0] CMP_LO_ADDR = 32'hFFFF_0008;
    localparam logic [31:0] CMP_HI_ADDR = 32'hFFFF_000C;
    localparam logic [31:0] CTRL_ADDR   = 32'hFFFF_0010;
    localparam logic [31:0] PERIOD_ADDR = 32'hFFFF_0014;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO_MAX,
        WR_HI,
        WR_LO
    } state_t;

    state_t      state_q, state_d;
    logic        reload_en_q, reload_en_d;
    logic        irq_en_q, irq_en_d;
    logic        pending_q, pending_d;
    logic [31:0] period_q, period_d;
    logic [31:0] per_q, per_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;

    logic        in_window;
    logic        ctrl_hit;
    logic        period_hit;
    logic        busy;
    logic        cpu_tmr_write;
    logic        ctrl_write;
    logic        start;
    logic [63:0] sum;

    always_comb begin
        in_window     = (cpu_address >= TMR_BASE) && (cpu_address <= TMR_LAST);
        ctrl_hit      = (cpu_address == CTRL_ADDR);
        period_hit    = (cpu_address == PERIOD_ADDR);
        busy          = (state_q != IDLE);
        cpu_tmr_write = cpu_write_enable && in_window;
        ctrl_write    = cpu_write_enable && ctrl_hit;
        // A CPU timer write in the detection cycle wins; the engine re-evaluates next cycle.
        start         = (state_q == IDLE) && tmr_interrupt && reload_en_q &&
                        (period_q != 32'd0) && !cpu_tmr_write;
        sum           = {hi_q, lo_q} + {32'd0, per_q};
    end

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_LO;
                    per_d   = period_q;
                end
            end
            RD_LO: begin
                lo_d    = tmr_read_data;
                state_d = RD_HI;
            end
            RD_HI: begin
                hi_d    = tmr_read_data;
                state_d = WR_LO_MAX;
            end
            WR_LO_MAX: state_d = WR_HI;
            WR_HI:     state_d = WR_LO;
            WR_LO:     state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        tmr_address      = cpu_address;
        tmr_write_data   = cpu_write_data;
        tmr_write_enable = 1'b0;
        unique case (state_q)
            IDLE: begin
                tmr_write_enable = cpu_tmr_write && rst;
            end
            RD_LO: begin
                tmr_address    = CMP_LO_ADDR;
                tmr_write_data = 32'd0;
            end
            RD_HI: begin
                tmr_address    = CMP_HI_ADDR;
                tmr_write_data = 32'd0;
            end
            // Parking the low word at all-ones keeps mtimecmp from dipping below mtime
            // while the high word is being replaced.
            WR_LO_MAX: begin
                tmr_address      = CMP_LO_ADDR;
                tmr_write_data   = 32'hFFFF_FFFF;
                tmr_write_enable = 1'b1;
            end
            WR_HI: begin
                tmr_address      = CMP_HI_ADDR;
                tmr_write_data   = sum[63:32];
                tmr_write_enable = 1'b1;
            end
            WR_LO: begin
                tmr_address      = CMP_LO_ADDR;
                tmr_write_data   = sum[31:0];
                tmr_write_enable = 1'b1;
            end
            default: begin
                tmr_address    = cpu_address;
                tmr_write_data = cpu_write_data;
            end
        endcase
    end

    always_comb begin
        cpu_read_data = 32'd0;
        if (in_window) begin
            cpu_read_data = busy ? 32'd0 : tmr_read_data;
        end else if (ctrl_hit) begin
            cpu_read_data = {29'd0, pending_q, irq_en_q, reload_en_q};
        end else if (period_hit) begin
            cpu_read_data = period_q;
        end
        cpu_stall = busy && in_window;
        irq       = pending_q && irq_en_q;
    end

    always_comb begin
        reload_en_d = reload_en_q;
        irq_en_d    = irq_en_q;
        period_d    = period_q;
        pending_d   = pending_q;
        if (ctrl_write) begin
            reload_en_d = cpu_write_data[0];
            irq_en_d    = cpu_write_data[1];
            if (cpu_write_data[2]) begin
                pending_d = 1'b0;
            end
        end
        if (cpu_write_enable && period_hit) begin
            period_d = cpu_write_data;
        end
        // Set beats a simultaneous write-1-to-clear.
        if (start || (!reload_en_q && tmr_interrupt)) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            reload_en_q <= 1'b0;
            irq_en_q    <= 1'b0;
            pending_q   <= 1'b0;
            period_q    <= 32'd0;
            per_q       <= 32'd0;
            lo_q        <= 32'd0;
            hi_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            reload_en_q <= reload_en_d;
            irq_en_q    <= irq_en_d;
            pending_q   <= pending_d;
            period_q    <= period_d;
            per_q       <= per_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
        end
    end
endmodule

// File: tb/tb_timer_reload_ctrl.sv
// tb/tb_timer_reload_ctrl.sv - self-checking bench for timer_reload_ctrl with a
// behavioural machine timer and a transaction-level controller model.
module tb_timer_reload_ctrl;
    localparam logic [31:0] MT_LO  = 32'hFFFF_0000;
    localparam logic [31:0] MT_HI  = 32'hFFFF_0004;
    localparam logic [31:0] CMP_LO = 32'hFFFF_0008;
    localparam logic [31:0] CMP_HI = 32'hFFFF_000C;
    localparam logic [31:0] CTRL   = 32'hFFFF_0010;
    localparam logic [31:0] PERIOD = 32'hFFFF_0014;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_address = 32'd0;
    logic [31:0] cpu_write_data = 32'd0;
    logic        cpu_write_enable = 1'b0;
    logic [31:0] cpu_read_data;
    logic        cpu_stall;
    logic [31:0] tmr_address;
    logic [31:0] tmr_write_data;
    logic        tmr_write_enable;
    logic [31:0] tmr_read_data;
    logic        tmr_interrupt;
    logic        irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    timer_reload_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .cpu_address      (cpu_address),
        .cpu_write_data   (cpu_write_data),
        .cpu_write_enable (cpu_write_enable),
        .cpu_read_data    (cpu_read_data),
        .cpu_stall        (cpu_stall),
        .tmr_address      (tmr_address),
        .tmr_write_data   (tmr_write_data),
        .tmr_write_enable (tmr_write_enable),
        .tmr_read_data    (tmr_read_data),
        .tmr_interrupt    (tmr_interrupt),
        .irq              (irq)
    );

    // Machine timer: mtime counts every cycle unless written; not affected by rst.
    logic [63:0] mtime_q    = 64'd0;
    logic [63:0] mtimecmp_q = 64'hFFFF_FFFF_FFFF_FFFF;

    always @(posedge clk) begin
        if (tmr_write_enable && tmr_address == MT_LO)      mtime_q <= {mtime_q[63:32], tmr_write_data};
        else if (tmr_write_enable && tmr_address == MT_HI) mtime_q <= {tmr_write_data, mtime_q[31:0]};
        else                                               mtime_q <= mtime_q + 64'd1;
        if (tmr_write_enable && tmr_address == CMP_LO) mtimecmp_q[31:0]  <= tmr_write_data;
        if (tmr_write_enable && tmr_address == CMP_HI) mtimecmp_q[63:32] <= tmr_write_data;
    end

    always_comb begin
        case (tmr_address)
            MT_LO:   tmr_read_data = mtime_q[31:0];
            MT_HI:   tmr_read_data = mtime_q[63:32];
            CMP_LO:  tmr_read_data = mtimecmp_q[31:0];
            CMP_HI:  tmr_read_data = mtimecmp_q[63:32];
            default: tmr_read_data = 32'd0;
        endcase
        tmr_interrupt = (mtime_q >= mtimecmp_q);
    end

    function automatic logic [31:0] timer_view(input logic [31:0] a, input logic [63:0] t, input logic [63:0] c);
        case (a)
            MT_LO:   return t[31:0];
            MT_HI:   return t[63:32];
            CMP_LO:  return c[31:0];
            CMP_HI:  return c[63:32];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic in_win(input logic [31:0] a);
        return (a >= MT_LO) && (a <= CMP_HI);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Controller model: registers plus a countdown of remaining engine cycles and
    // the precomputed target mtimecmp.
    logic        m_reload_en = 1'b0;
    logic        m_irq_en    = 1'b0;
    logic        m_pending   = 1'b0;
    logic [31:0] m_period    = 32'd0;
    int          m_busy      = 0;
    logic [63:0] m_sum       = 64'd0;
    logic [63:0] m_cmp       = 64'hFFFF_FFFF_FFFF_FFFF;

    always @(negedge clk) begin
        logic        win, busy, cpu_tw, start, e_we;
        logic [31:0] e_addr, e_data, e_rd;
        int          k;
        if (!rst) begin
            m_reload_en = 1'b0;
            m_irq_en    = 1'b0;
            m_pending   = 1'b0;
            m_period    = 32'd0;
            m_busy      = 0;
            m_sum       = 64'd0;
        end
        win    = in_win(cpu_address);
        busy   = (m_busy != 0);
        cpu_tw = cpu_write_enable && win;
        k      = 5 - m_busy;
        e_we   = 1'b0;
        e_addr = cpu_address;
        e_data = cpu_write_data;
        if (!busy) begin
            e_we = cpu_tw && rst;
        end else begin
            case (k)
                0: e_addr = CMP_LO;
                1: e_addr = CMP_HI;
                2: begin e_addr = CMP_LO; e_we = 1'b1; e_data = 32'hFFFF_FFFF; end
                3: begin e_addr = CMP_HI; e_we = 1'b1; e_data = m_sum[63:32]; end
                default: begin e_addr = CMP_LO; e_we = 1'b1; e_data = m_sum[31:0]; end
            endcase
        end
        if (win)                       e_rd = busy ? 32'd0 : timer_view(cpu_address, mtime_q, mtimecmp_q);
        else if (cpu_address == CTRL)   e_rd = {29'd0, m_pending, m_irq_en, m_reload_en};
        else if (cpu_address == PERIOD) e_rd = m_period;
        else                            e_rd = 32'd0;

        chk("cpu_stall", cpu_stall, busy && win);
        chk("irq", irq, m_pending && m_irq_en);
        chk("tmr_write_enable", tmr_write_enable, e_we);
        chk("tmr_address", tmr_address, e_addr);
        if (!busy || e_we) chk("tmr_write_data", tmr_write_data, e_data);
        chk("cpu_read_data", cpu_read_data, e_rd);

        if (rst) begin
            start = !busy && tmr_interrupt && m_reload_en && (m_period != 0) && !cpu_tw;
            if (cpu_write_enable && cpu_address == CTRL && cpu_write_data[2]) m_pending = 1'b0;
            if (start || (!m_reload_en && tmr_interrupt)) m_pending = 1'b1;
            if (!busy && cpu_tw && cpu_address == CMP_LO) m_cmp[31:0]  = cpu_write_data;
            if (!busy && cpu_tw && cpu_address == CMP_HI) m_cmp[63:32] = cpu_write_data;
            if (busy) begin
                if (k == 2) m_cmp[31:0]  = 32'hFFFF_FFFF;
                if (k == 3) m_cmp[63:32] = m_sum[63:32];
                if (k == 4) m_cmp[31:0]  = m_sum[31:0];
                m_busy--;
            end
            if (start) begin
                m_busy = 5;
                m_sum  = m_cmp + {32'd0, m_period};
            end
            if (cpu_write_enable && cpu_address == CTRL) begin
                m_reload_en = cpu_write_data[0];
                m_irq_en    = cpu_write_data[1];
            end
            if (cpu_write_enable && cpu_address == PERIOD) m_period = cpu_write_data;
        end
    end

    logic [31:0] log_a[$];
    logic [31:0] log_d[$];
    always @(negedge clk) begin
        if (rst && tmr_write_enable && !cpu_write_enable) begin
            log_a.push_back(tmr_address);
            log_d.push_back(tmr_write_data);
        end
    end

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        int   n;
        logic st;
        n = 0;
        cpu_address      = a;
        cpu_write_data   = d;
        cpu_write_enable = 1'b1;
        do begin
            @(negedge clk);
            st = cpu_stall;
            @(posedge clk);
            #1;
            n++;
        end while (st && n < 100);
        if (st) chk("write_timeout", 0, 1);
        cpu_write_enable = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output int stalls);
        int   n;
        logic st;
        n = 0;
        stalls = 0;
        cpu_address      = a;
        cpu_write_enable = 1'b0;
        do begin
            @(negedge clk);
            st = cpu_stall;
            d  = cpu_read_data;
            if (st) stalls++;
            @(posedge clk);
            #1;
            n++;
        end while (st && n < 100);
        if (st) chk("read_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        cpu_write_enable = 1'b0;
        cpu_address      = 32'd0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_irq(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!irq && n < 2000);
        chk(name, irq, 1);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] addrs[8] = '{32'hFFFF_0000, 32'hFFFF_0004, 32'hFFFF_0008, 32'hFFFF_000C,
                              32'hFFFF_0010, 32'hFFFF_0014, 32'hFFFF_0018, 32'h0000_1000};

    initial begin
        logic [31:0] d;
        int          s;
        int          n;

        rst = 1'b0;
        cpu_address = CMP_LO;
        cpu_write_data = 32'h55;
        cpu_write_enable = 1'b1;
        step(3);
        chk("reset_tmr_we", tmr_write_enable, 0);
        chk("reset_irq", irq, 0);
        chk("reset_stall", cpu_stall, 0);
        cpu_write_enable = 1'b0;
        rst = 1'b1;
        cpu_read(CTRL, d, s);   chk("ctrl_after_reset", d, 0);
        cpu_read(PERIOD, d, s); chk("period_after_reset", d, 0);

        // Pass-through with reload disabled.
        cpu_write(CTRL, 32'd0);
        cpu_write(CMP_LO, 32'h100);
        cpu_write(CMP_HI, 32'd0);
        cpu_read(CMP_LO, d, s);
        chk("pt_cmp_lo", d, 32'h100);
        chk("pt_no_stall", s, 0);
        chk("pt_irq_off", irq, 0);

        // Auto-reload: trigger at mtime 50, new mtimecmp 150.
        cpu_write(MT_LO, 32'd0);
        cpu_write(CMP_LO, 32'd50);
        cpu_write(PERIOD, 32'd100);
        cpu_write(CTRL, 32'd3);
        cpu_address = MT_LO;
        wait_irq("ar_irq_rise");
        chk("ar_irq_mtime", mtime_q, 64'd51);
        s = 0;
        while (cpu_stall && s < 20) begin
            s++;
            @(negedge clk);
        end
        chk("ar_busy_cycles", s, 5);
        step(1);
        cpu_read(CMP_LO, d, s);
        chk("ar_cmp_150", d, 32'd150);
        chk("ar_irq_high", irq, 1);
        cpu_write(CTRL, 32'h7);
        cpu_address = 32'd0;
        @(negedge clk);
        chk("ar_irq_cleared", irq, 0);
        step(1);
        wait_irq("ar_irq_second");
        chk("ar_second_mtime", mtime_q, 64'd151);
        step(1);

        // Carry across the word boundary and the lo-max/hi/lo order.
        cpu_write(CTRL, 32'd0);
        cpu_write(CMP_HI, 32'd1);
        cpu_write(CMP_LO, 32'hFFFF_FFF0);
        cpu_write(MT_LO, 32'hFFFF_FF00);
        cpu_write(MT_HI, 32'd1);
        cpu_write(PERIOD, 32'h20);
        log_a.delete();
        log_d.delete();
        cpu_write(CTRL, 32'd1);
        cpu_address = 32'd0;
        n = 0;
        while (log_a.size() < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        step(2);
        chk("carry_write_count", log_a.size(), 3);
        if (log_a.size() >= 3) begin
            chk("carry_w0_addr", log_a[0], CMP_LO); chk("carry_w0_data", log_d[0], 32'hFFFF_FFFF);
            chk("carry_w1_addr", log_a[1], CMP_HI); chk("carry_w1_data", log_d[1], 32'h2);
            chk("carry_w2_addr", log_a[2], CMP_LO); chk("carry_w2_data", log_d[2], 32'h10);
        end
        cpu_read(CMP_LO, d, s); chk("carry_cmp_lo", d, 32'h10);
        cpu_read(CMP_HI, d, s); chk("carry_cmp_hi", d, 32'h2);
        cpu_write(CTRL, 32'd0);
        cpu_write(MT_LO, 32'd0);
        cpu_write(MT_HI, 32'd0);
        cpu_write(CMP_LO, 32'hFFFF_FFFF);
        cpu_write(CMP_HI, 32'd0);

        // Contention: read stalled from RD_HI until IDLE.
        cpu_write(CMP_LO, 32'd100);
        cpu_write(PERIOD, 32'd50);
        cpu_write(CTRL, 32'h7);
        cpu_address = 32'd0;
        wait_irq("ct_irq_rise");
        step(1);
        cpu_read(MT_LO, d, s);
        chk("ct_rdhi_stalls", s, 4);
        chk("ct_rdhi_data", d, 32'd106);

        // PERIOD written during WR_HI leaves the in-flight sum alone.
        cpu_write(CTRL, 32'h7);
        cpu_address = 32'd0;
        wait_irq("ct_irq_period");
        step(3);
        cpu_write(PERIOD, 32'd77);
        idle(3);
        cpu_read(CMP_LO, d, s); chk("ct_old_period_sum", d, 32'd200);
        cpu_write(CTRL, 32'h7);
        cpu_address = 32'd0;
        wait_irq("ct_irq_newper");
        idle(6);
        cpu_read(CMP_LO, d, s); chk("ct_new_period_sum", d, 32'd277);

        // CPU timer write in the detection cycle wins; the engine starts one cycle later.
        cpu_write(CTRL, 32'h7);
        cpu_address = 32'd0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mtime_q != 64'd276 && n < 2000);
        chk("sc_reach_276", mtime_q, 64'd276);
        @(posedge clk);
        #1;
        cpu_address = CMP_HI;
        cpu_write_data = 32'd0;
        cpu_write_enable = 1'b1;
        @(negedge clk);
        chk("sc_cpu_forwarded", tmr_write_enable, 1);
        chk("sc_irq_n0", irq, 0);
        @(posedge clk);
        #1;
        cpu_write_enable = 1'b0;
        cpu_address = 32'd0;
        @(negedge clk);
        chk("sc_irq_n1", irq, 0);
        @(negedge clk);
        chk("sc_irq_n2", irq, 1);
        idle(6);
        cpu_read(CMP_LO, d, s); chk("sc_cmp", d, 32'd354);

        // Asynchronous reset in WR_HI.
        cpu_write(CTRL, 32'h7);
        cpu_address = 32'd0;
        wait_irq("ar2_irq_rise");
        step(3);
        rst = 1'b0;
        #1;
        chk("ar2_we_dropped", tmr_write_enable, 0);
        chk("ar2_irq_zero", irq, 0);
        chk("ar2_stall_zero", cpu_stall, 0);
        step(2);
        rst = 1'b1;
        cpu_read(CTRL, d, s);   chk("ar2_ctrl", d, 0);
        cpu_read(PERIOD, d, s); chk("ar2_period", d, 0);
        cpu_read(CMP_LO, d, s);
        chk("ar2_cmp_lo_max", d, 32'hFFFF_FFFF);
        chk("ar2_idle_no_stall", s, 0);

        // Randomized traffic around a free-running timer.
        cpu_write(CMP_LO, mtime_q[31:0] + 32'd40);
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    cpu_write(CTRL, 32'($urandom_range(0, 7)));
                2:       cpu_write(PERIOD, 32'($urandom_range(0, 40)));
                3:       cpu_write(CMP_LO, mtime_q[31:0] + 32'($urandom_range(0, 80)));
                4:       cpu_write(CMP_HI, 32'd0);
                5, 6, 7: cpu_read(addrs[$urandom_range(0, 7)], d, s);
                default: idle($urandom_range(1, 8));
            endcase
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
